// File: rtl/regram_wr_sched_pkg.sv
// Shared types for the register-RAM write scheduler.
// The request struct is sized to the largest supported widths; the top slices it.
package regram_wr_sched_pkg;

   localparam int WR_MAX_AW = 16;
   localparam int WR_MAX_DW = 128;

   typedef enum logic {S_INIT, S_RUN} sched_state_e;

   typedef struct packed {
      logic [WR_MAX_AW-1:0] addr;
      logic [WR_MAX_DW-1:0] data;
   } wr_req_t;

   // Round-robin pointer width; a lone requester still needs one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regram_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after rr_ptr, wrapping modulo NUM_REQ. Output is one-hot or all-zero.
module regram_wr_sched_rr_arbiter
   import regram_wr_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int PW = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] gnt
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] hi;
   logic [NUM_REQ-1:0] pool;

   // Prefer requesters at/above the pointer; fall back to the wrapped set.
   always_comb begin
      mask = '0;
      for (int j = 0; j < NUM_REQ; j++) mask[j] = (PW'(j) >= rr_ptr);
      hi   = valid & mask;
      pool = (hi != '0) ? hi : valid;
      gnt  = pool & (~pool + ONE);
   end

endmodule

// File: rtl/regram_wr_sched.sv
// Write-port scheduler for a single-write-port register RAM.
// Define REGRAM_WR_SCHED_INIT_EN to sweep INIT_VALUE into every entry after reset.
module regram_wr_sched
   import regram_wr_sched_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DATA_DEPTH = 64,
   parameter int                    NUM_REQ    = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int                   AW         = $clog2(DATA_DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_valid_i,
   input  logic [NUM_REQ-1:0][AW-1:0]          req_addr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]                  req_ready_o,
   output logic                                init_done_o,
   output logic                                ram_we_o,
   output logic [AW-1:0]                       ram_waddr_o,
   output logic [DATA_WIDTH-1:0]               ram_wdata_o
);

   localparam int PW = ptr_w(NUM_REQ);
   localparam int CW = AW + 1;

   sched_state_e       state;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      rr_next;
   logic [PW-1:0]      g_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               run_ok;
   logic               hs;
   wr_req_t            win;
   logic               unused_win;

   regram_wr_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid  (req_valid_i),
      .rr_ptr (rr_ptr),
      .gnt    (gnt)
   );

   // Ready is gated by rst_n so nothing is granted while reset is held.
   assign run_ok      = (state == S_RUN) && rst_n;
   assign req_ready_o = run_ok ? gnt : '0;
   assign hs          = run_ok && (gnt != '0);

   always_comb begin
      win   = '0;
      g_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (gnt[j]) begin
            g_idx                     = PW'(j);
            win.addr[AW-1:0]          = req_addr_i[j];
            win.data[DATA_WIDTH-1:0]  = req_data_i[j];
         end
      end
   end

   assign unused_win = ^win;
   assign rr_next    = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);

`ifdef REGRAM_WR_SCHED_INIT_EN
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_INIT;
         cnt         <= '0;
         init_done_o <= 1'b0;
         rr_ptr      <= '0;
         ram_we_o    <= 1'b0;
         ram_waddr_o <= '0;
         ram_wdata_o <= '0;
      end else begin
         case (state)
            S_INIT: begin
               ram_we_o    <= 1'b1;
               ram_waddr_o <= cnt[AW-1:0];
               ram_wdata_o <= INIT_VALUE;
               cnt         <= cnt + CW'(1);
               if (cnt == CW'(DATA_DEPTH - 1)) begin
                  state       <= S_RUN;
                  init_done_o <= 1'b1;
               end
            end
            S_RUN: begin
               if (hs) begin
                  ram_we_o    <= 1'b1;
                  ram_waddr_o <= win.addr[AW-1:0];
                  ram_wdata_o <= win.data[DATA_WIDTH-1:0];
                  rr_ptr      <= rr_next;
               end else begin
                  ram_we_o    <= 1'b0;
               end
            end
            default: ram_we_o <= 1'b0;
         endcase
      end
   end
`else
   // No sweep: the RAM comes out of reset with undefined contents.
   logic unused_init;
   assign unused_init = ^{INIT_VALUE, CW'(0)};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_RUN;
         init_done_o <= 1'b1;
         rr_ptr      <= '0;
         ram_we_o    <= 1'b0;
         ram_waddr_o <= '0;
         ram_wdata_o <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (hs) begin
                  ram_we_o    <= 1'b1;
                  ram_waddr_o <= win.addr[AW-1:0];
                  ram_wdata_o <= win.data[DATA_WIDTH-1:0];
                  rr_ptr      <= rr_next;
               end else begin
                  ram_we_o    <= 1'b0;
               end
            end
            default: ram_we_o <= 1'b0;
         endcase
      end
   end
`endif

endmodule

// File: doc/regram_wr_sched.md
Name: regram_wr_sched

Overview:
Write-port scheduler for a single-write-port register RAM with 0-latency read.
- After reset, sweeps every entry to INIT_VALUE so the RAM itself needs no reset logic.
- Then shares the single write port between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Drives the RAM write port from a registered stage. Sits between rename/commit-style producers and the RAM instance.

Parameters:
DATA_WIDTH, 32, width of write data.
DATA_DEPTH, 64, number of RAM entries; power of two, >= 2.
NUM_REQ, 2, number of write requesters; >= 1.
INIT_VALUE, '0, DATA_WIDTH-bit value written to every entry during the init sweep.
Derived: AW = $clog2(DATA_DEPTH).

Ports:
clk  in  1  clock; every flop is clocked on its rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid_i  in  NUM_REQ  per-requester write request.
req_addr_i  in  NUM_REQ x AW  per-requester write address.
req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester write data.
req_ready_o  out  NUM_REQ  grant; a write is accepted on a cycle where valid & ready are both high.
init_done_o  out  1  high once the init sweep has completed.
ram_we_o  out  1  RAM write enable (registered).
ram_waddr_o  out  AW  RAM write address (registered).
ram_wdata_o  out  DATA_WIDTH  RAM write data (registered).

Behaviour:
Interface (already decided): one clock, clk; reset is synchronous and active-low, rst_n.

Reset (rst_n low at a clock edge):
- state=INIT, cnt=0, rr_ptr=0.
- ram_we_o=0, ram_waddr_o=0, ram_wdata_o=0, init_done_o=0.
- req_ready_o is all-zero while in reset and throughout INIT.

FSM, two states: INIT and RUN.

INIT:
- On each edge, the output stage loads we=1, waddr=cnt, wdata=INIT_VALUE, then cnt increments.
- The edge that loads cnt=DATA_DEPTH-1 also sets state=RUN and init_done_o=1.
- The sweep therefore takes exactly DATA_DEPTH write cycles.
- cnt is AW+1 bits wide; it must not wrap before the transition.

RUN:
- Grant is combinational: the first valid requester at or after rr_ptr, searching upward modulo NUM_REQ.
- req_ready_o is one-hot on the granted index, and zero if no requester is valid.
- ready depends on req_valid_i only within the same cycle, and never on the requester's address or data.
- On a handshake at index g:
  - the output stage loads we=1, waddr=req_addr_i[g], wdata=req_data_i[g];
  - rr_ptr becomes (g+1) mod NUM_REQ.
- With no handshake, the next edge loads ram_we_o=0, and waddr/wdata hold their previous values.
  - rr_ptr is unchanged.
- Throughput: one write per cycle.
- Latency: a handshake in cycle N produces ram_we_o=1 in cycle N+1; RAM contents update at the end of N+1.

Boundary conditions:
- Same address from successive grants: writes land in grant order, so the last granted one wins.
- Reads of an address during the cycle its write is on ram_we_o return the old value. The RAM is 0-latency with no forwarding, and this block adds none.
- Reset asserted mid-sweep or mid-RUN: the in-flight registered write is dropped (ram_we_o=0 after that edge), and the sweep restarts from address 0.
- NUM_REQ=1: rr_ptr is constant 0; ready equals valid in RUN.
- Valid dropped without a handshake is legal; a requester need not hold its request.

Optional Feature:
Macro REGRAM_WR_SCHED_INIT_EN.
- Defined: INIT sweep behaves as described above.
- Undefined:
  - reset places the FSM directly in RUN, and init_done_o is 1 from the first post-reset cycle;
  - no INIT writes are issued, and cnt logic is removed;
  - INIT_VALUE is ignored and RAM contents after reset are undefined.

Decomposition:
Shared package:
- state enum typedef, sched_state_e {S_INIT, S_RUN};
- write-request struct typedef, wr_req_t {addr, data}, parameterised through package-level width constants.

One sub-module is natural: rr_arbiter.
- Parameter: NUM_REQ.
- Inputs: valid vector, rr_ptr. Output: one-hot grant, purely combinational.
- The pointer update stays in regram_wr_sched.

Test Plan (NUM_REQ=3, DATA_DEPTH=16, INIT_VALUE=32'hDEAD_BEEF unless stated):
- Release reset, idle inputs -> ram_we_o high for exactly 16 consecutive cycles with waddr 0..15 and wdata DEADBEEF; init_done_o rises on the edge that loads waddr 15; no ready during sweep.
- After init, all three valid constantly, addrs 1/2/3 -> grants 0,1,2,0,1,2; ram_waddr_o sequence 1,2,3,1,2,3, each one cycle after its handshake.
- After init, only req 2 valid with addr 5 data 0xA5 -> ready[2] same cycle; next cycle we=1, waddr=5, wdata=0xA5; following cycle with no valid -> we=0.
- Reqs 0 and 1 both target addr 7 with data 0x11 and 0x22, rr_ptr=0 -> writes 0x11 then 0x22; backdoor read of addr 7 afterwards = 0x22.
- Assert rst_n low at sweep address 9 for one cycle -> we=0 after that edge; sweep restarts at waddr 0 and completes all 16 entries.
- Build without REGRAM_WR_SCHED_INIT_EN -> init_done_o=1 and ready asserted on the first cycle after reset release; no sweep writes.
